// File: rtl/usb_packet_rx.sv
// rtl/usb_packet_rx.sv - full-speed USB packet receiver (NRZI, SYNC, PID, unstuff, bytes, CRC16, EOP); optional CRC via USB_RX_CRC_EN
module usb_packet_rx #(
    parameter int MAX_BYTES = 70,
    parameter int CNT_W     = 7
) (
    input  logic             useClk,
    input  logic             rst,
    input  logic             checkData,
    input  logic             rxLine,
    input  logic             rxSe0,
    output logic [3:0]       pidOut,
    output logic             pidValid,
    output logic [7:0]       dataByte,
    output logic             dataValid,
    output logic [CNT_W-1:0] byteCount,
    output logic             packetDone,
    output logic             crcOk,
    output logic             errPid,
    output logic             errStuff,
    output logic             errAlign,
    output logic             errOverflow
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PID   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_ABORT = 3'd3;
    localparam logic [2:0] ST_WAITJ = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             prev_line_q, prev_line_d;
    logic             se0_prev_q, se0_prev_d;
    logic [7:0]       hist_q, hist_d;
    logic [2:0]       ones_q, ones_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       sreg_q, sreg_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]       pid_q, pid_d;
    logic             pid_valid_q, pid_valid_d;
    logic [7:0]       data_byte_q, data_byte_d;
    logic             data_valid_q, data_valid_d;
    logic             packet_done_q, packet_done_d;
    logic             crc_ok_q, crc_ok_d;
    logic             err_pid_q, err_pid_d;
    logic             err_stuff_q, err_stuff_d;
    logic             err_align_q, err_align_d;
    logic             err_ovf_q, err_ovf_d;
`ifdef USB_RX_CRC_EN
    logic [15:0]      crc_q, crc_d;
    logic             data_pid_q, data_pid_d;
`endif

    logic       dec_bit;
    logic [7:0] hist_next;
    logic [7:0] sreg_next;

    // NRZI: no transition means a 1; bytes arrive LSB first so new bits enter at the top
    assign dec_bit   = (rxLine == prev_line_q);
    assign hist_next = {hist_q[6:0], dec_bit};
    assign sreg_next = {dec_bit, sreg_q[7:1]};

    // Next-state logic; nothing moves and no pulse fires without a checkData strobe
    always_comb begin
        state_d       = state_q;
        prev_line_d   = prev_line_q;
        se0_prev_d    = se0_prev_q;
        hist_d        = hist_q;
        ones_d        = ones_q;
        bit_cnt_d     = bit_cnt_q;
        sreg_d        = sreg_q;
        byte_cnt_d    = byte_cnt_q;
        pid_d         = pid_q;
        pid_valid_d   = 1'b0;
        data_byte_d   = data_byte_q;
        data_valid_d  = 1'b0;
        packet_done_d = 1'b0;
        crc_ok_d      = crc_ok_q;
        err_pid_d     = err_pid_q;
        err_stuff_d   = err_stuff_q;
        err_align_d   = err_align_q;
        err_ovf_d     = err_ovf_q;
`ifdef USB_RX_CRC_EN
        crc_d         = crc_q;
        data_pid_d    = data_pid_q;
`endif
        if (checkData) begin
            se0_prev_d = rxSe0;
            if (!rxSe0) begin
                prev_line_d = rxLine;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rxSe0) begin
                        hist_d = hist_next;
                        if (hist_next == 8'b0000_0001) begin
                            state_d     = ST_PID;
                            ones_d      = 3'd0;
                            bit_cnt_d   = 3'd0;
                            byte_cnt_d  = '0;
                            crc_ok_d    = 1'b0;
                            err_pid_d   = 1'b0;
                            err_stuff_d = 1'b0;
                            err_align_d = 1'b0;
                            err_ovf_d   = 1'b0;
`ifdef USB_RX_CRC_EN
                            crc_d       = 16'hFFFF;
                            data_pid_d  = 1'b0;
`endif
                        end
                    end
                end
                ST_PID, ST_DATA, ST_ABORT: begin
                    if (rxSe0) begin
                        // EOP needs two SE0 strobes in a row; a lone SE0 strobe is a glitch
                        if (se0_prev_q) begin
                            err_align_d   = (state_q == ST_PID) ||
                                            ((state_q == ST_DATA) && (bit_cnt_q != 3'd0));
`ifdef USB_RX_CRC_EN
                            crc_ok_d      = data_pid_q ? (crc_q == 16'h800D) : 1'b1;
`else
                            crc_ok_d      = 1'b1;
`endif
                            packet_done_d = 1'b1;
                            state_d       = ST_WAITJ;
                        end
                    end else if (state_q != ST_ABORT) begin
                        if (ones_q == 3'd6) begin
                            // Stuff slot: a 0 is dropped, a 1 is a protocol violation
                            if (dec_bit) begin
                                err_stuff_d = 1'b1;
                                state_d     = ST_ABORT;
                            end else begin
                                ones_d = 3'd0;
                            end
                        end else begin
                            ones_d    = dec_bit ? (ones_q + 3'd1) : 3'd0;
                            sreg_d    = sreg_next;
                            bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef USB_RX_CRC_EN
                            if ((state_q == ST_DATA) && data_pid_q) begin
                                crc_d = {crc_q[14:0], 1'b0} ^
                                        ((crc_q[15] ^ dec_bit) ? 16'h8005 : 16'h0000);
                            end
`endif
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == ST_PID) begin
                                    if (sreg_next[3:0] == ~sreg_next[7:4]) begin
                                        pid_d       = sreg_next[3:0];
                                        pid_valid_d = 1'b1;
                                        state_d     = ST_DATA;
`ifdef USB_RX_CRC_EN
                                        data_pid_d  = (sreg_next[3:0] == 4'h3) ||
                                                      (sreg_next[3:0] == 4'hB);
`endif
                                    end else begin
                                        err_pid_d = 1'b1;
                                        state_d   = ST_ABORT;
                                    end
                                end else if (byte_cnt_q == CNT_W'(MAX_BYTES)) begin
                                    err_ovf_d = 1'b1;
                                    state_d   = ST_ABORT;
                                end else begin
                                    data_byte_d  = sreg_next;
                                    data_valid_d = 1'b1;
                                    byte_cnt_d   = byte_cnt_q + 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_WAITJ: begin
                    if (!rxSe0 && rxLine) begin
                        state_d     = ST_IDLE;
                        prev_line_d = 1'b1;
                        hist_d      = 8'h00;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge useClk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            prev_line_q   <= 1'b1;
            se0_prev_q    <= 1'b0;
            hist_q        <= 8'h00;
            ones_q        <= 3'd0;
            bit_cnt_q     <= 3'd0;
            sreg_q        <= 8'h00;
            byte_cnt_q    <= '0;
            pid_q         <= 4'h0;
            pid_valid_q   <= 1'b0;
            data_byte_q   <= 8'h00;
            data_valid_q  <= 1'b0;
            packet_done_q <= 1'b0;
            crc_ok_q      <= 1'b0;
            err_pid_q     <= 1'b0;
            err_stuff_q   <= 1'b0;
            err_align_q   <= 1'b0;
            err_ovf_q     <= 1'b0;
`ifdef USB_RX_CRC_EN
            crc_q         <= 16'hFFFF;
            data_pid_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            prev_line_q   <= prev_line_d;
            se0_prev_q    <= se0_prev_d;
            hist_q        <= hist_d;
            ones_q        <= ones_d;
            bit_cnt_q     <= bit_cnt_d;
            sreg_q        <= sreg_d;
            byte_cnt_q    <= byte_cnt_d;
            pid_q         <= pid_d;
            pid_valid_q   <= pid_valid_d;
            data_byte_q   <= data_byte_d;
            data_valid_q  <= data_valid_d;
            packet_done_q <= packet_done_d;
            crc_ok_q      <= crc_ok_d;
            err_pid_q     <= err_pid_d;
            err_stuff_q   <= err_stuff_d;
            err_align_q   <= err_align_d;
            err_ovf_q     <= err_ovf_d;
`ifdef USB_RX_CRC_EN
            crc_q         <= crc_d;
            data_pid_q    <= data_pid_d;
`endif
        end
    end

    assign pidOut      = pid_q;
    assign pidValid    = pid_valid_q;
    assign dataByte    = data_byte_q;
    assign dataValid   = data_valid_q;
    assign byteCount   = byte_cnt_q;
    assign packetDone  = packet_done_q;
    assign crcOk       = crc_ok_q;
    assign errPid      = err_pid_q;
    assign errStuff    = err_stuff_q;
    assign errAlign    = err_align_q;
    assign errOverflow = err_ovf_q;

endmodule

// File: tb/tb_usb_packet_rx.sv
// tb/tb_usb_packet_rx.sv - directed bench for usb_packet_rx
module tb_usb_packet_rx;

    logic       useClk = 1'b0;
    logic       rst = 1'b1;
    logic       checkData = 1'b0;
    logic       rxLine = 1'b1;
    logic       rxSe0 = 1'b0;
    logic [3:0] pidOut;
    logic       pidValid;
    logic [7:0] dataByte;
    logic       dataValid;
    logic [6:0] byteCount;
    logic       packetDone;
    logic       crcOk;
    logic       errPid;
    logic       errStuff;
    logic       errAlign;
    logic       errOverflow;

    usb_packet_rx #(.MAX_BYTES(70), .CNT_W(7)) dut (
        .useClk(useClk), .rst(rst), .checkData(checkData), .rxLine(rxLine), .rxSe0(rxSe0),
        .pidOut(pidOut), .pidValid(pidValid), .dataByte(dataByte), .dataValid(dataValid),
        .byteCount(byteCount), .packetDone(packetDone), .crcOk(crcOk), .errPid(errPid),
        .errStuff(errStuff), .errAlign(errAlign), .errOverflow(errOverflow)
    );

    always #5 useClk = ~useClk;

    int n_tests = 0;
    int n_fail = 0;

    // Pulse monitor: counts pulses and captures bytes away from the rising edge
    int         mon_pid = 0;
    int         mon_data = 0;
    int         mon_done = 0;
    logic [3:0] mon_last_pid = 4'h0;
    logic [7:0] mon_bytes [0:255];
    always @(negedge useClk) begin
        if (pidValid) begin
            mon_pid = mon_pid + 1;
            mon_last_pid = pidOut;
        end
        if (dataValid) begin
            mon_bytes[mon_data % 256] = dataByte;
            mon_data = mon_data + 1;
        end
        if (packetDone) mon_done = mon_done + 1;
    end

    logic        tx_line = 1'b1;
    int          tx_ones = 0;
    logic [15:0] tx_crc = 16'hFFFF;
    int          b_pid, b_data, b_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic line, input logic se0);
        @(negedge useClk);
        rxLine = line;
        rxSe0 = se0;
        checkData = 1'b1;
        @(negedge useClk);
        checkData = 1'b0;
    endtask

    task automatic send_raw(input logic b);
        if (!b) tx_line = ~tx_line;
        strobe(tx_line, 1'b0);
    endtask

    task automatic send_bit(input logic b);
        send_raw(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 6) begin
                send_raw(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic upd_crc);
        for (int i = 0; i < 8; i++) begin
            if (upd_crc)
                tx_crc = {tx_crc[14:0], 1'b0} ^ ((tx_crc[15] ^ v[i]) ? 16'h8005 : 16'h0000);
            send_bit(v[i]);
        end
    endtask

    task automatic send_crc();
        logic [15:0] c;
        c = ~tx_crc;
        for (int i = 15; i >= 0; i--) send_bit(c[i]);
    endtask

    task automatic start_pkt(input logic [7:0] pid);
        b_pid = mon_pid;
        b_data = mon_data;
        b_done = mon_done;
        for (int i = 0; i < 7; i++) send_raw(1'b0);
        send_raw(1'b1);
        tx_ones = 0;
        tx_crc = 16'hFFFF;
        send_byte(pid, 1'b0);
    endtask

    task automatic send_eop();
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        tx_line = 1'b1;
        strobe(1'b1, 1'b0);
        tx_ones = 0;
        repeat (2) @(negedge useClk);
    endtask

    task automatic chk_pkt(input string t, input int npid, input logic [3:0] pid, input int ndata,
                           input int bc, input logic chk_crc, input logic crc,
                           input logic ep, input logic es, input logic ea, input logic eo);
        chk({t, ".pid_pulses"}, mon_pid - b_pid, npid);
        if (npid > 0) chk({t, ".pidOut"}, mon_last_pid, pid);
        chk({t, ".data_pulses"}, mon_data - b_data, ndata);
        chk({t, ".done_pulses"}, mon_done - b_done, 1);
        chk({t, ".byteCount"}, byteCount, bc);
        if (chk_crc) chk({t, ".crcOk"}, crcOk, crc);
        chk({t, ".errPid"}, errPid, ep);
        chk({t, ".errStuff"}, errStuff, es);
        chk({t, ".errAlign"}, errAlign, ea);
        chk({t, ".errOverflow"}, errOverflow, eo);
    endtask

    task automatic chk_all_zero(input string t);
        chk({t, ".outs"}, {pidOut, pidValid, dataByte, dataValid, byteCount, packetDone,
                           crcOk, errPid, errStuff, errAlign, errOverflow}, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge useClk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge useClk);

        // DATA0 zero-length: C3 00 00
        start_pkt(8'hC3);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_eop();
        chk_pkt("t1", 1, 4'h3, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1.byte0", mon_bytes[b_data % 256], 8'h00);
        chk("t1.byte1", mon_bytes[(b_data + 1) % 256], 8'h00);

        // DATA1 FF FF with stuffing and a correct CRC
        start_pkt(8'h4B);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_crc();
        send_eop();
        chk_pkt("t2", 1, 4'hB, 4, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2.byte0", mon_bytes[b_data % 256], 8'hFF);
        chk("t2.byte1", mon_bytes[(b_data + 1) % 256], 8'hFF);

        // Bad PID check field
        start_pkt(8'hC4);
        send_eop();
        chk_pkt("t3", 0, 4'h0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Seven ones after PID: stuff violation
        start_pkt(8'hC3);
        for (int i = 0; i < 7; i++) send_raw(1'b1);
        send_eop();
        chk_pkt("t4", 1, 4'h3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // C3 00 01: CRC residual wrong
        start_pkt(8'hC3);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_eop();
`ifdef USB_RX_CRC_EN
        chk_pkt("t5", 1, 4'h3, 2, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        chk_pkt("t5", 1, 4'h3, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        chk("t5.byte1", mon_bytes[(b_data + 1) % 256], 8'h01);

        // Lone SE0 glitch ignored, then EOP with a partial byte
        start_pkt(8'hC3);
        send_byte(8'h00, 1'b1);
        strobe(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_raw(1'b0);
        send_eop();
        chk_pkt("t6", 1, 4'h3, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 71 bytes after PID: overflow on the last one
        start_pkt(8'hC3);
        for (int i = 0; i < 71; i++) send_byte(8'h00, 1'b1);
        send_eop();
        chk_pkt("t7", 1, 4'h3, 70, 70, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during the second data byte, then the first packet again
        start_pkt(8'hC3);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) send_raw(1'b0);
        @(negedge useClk);
        rst = 1'b1;
        #1;
        chk_all_zero("t8.rst");
        repeat (2) @(negedge useClk);
        rst = 1'b0;
        chk("t8.no_done", mon_done - b_done, 0);
        tx_line = 1'b1;
        tx_ones = 0;
        repeat (2) @(negedge useClk);
        start_pkt(8'hC3);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_eop();
        chk_pkt("t8", 1, 4'h3, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t8.byte1", mon_bytes[(b_data + 1) % 256], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
